// File: rtl/param_dff_pkg.sv
// Shared helpers for param_dff: flop polarity encoding so every storage
// flop can stay reset-to-0 regardless of the requested reset value.
package param_dff_pkg;

  // Bits whose reset value is 1 are stored inverted; the same XOR decodes them.
  function automatic logic stored_bit(input logic b, input logic rv);
    return b ^ rv;
  endfunction

endpackage

// File: rtl/param_dff_if.sv
// Data bundle for a param_dff instance: d toward the pipeline, q back out.
interface param_dff_if #(
  parameter int WIDTH = 1
);
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;

  modport master (output d, input q);
  modport slave (input d, output q);
endinterface

// File: rtl/param_dff_d_ff.sv
// One-bit D flip-flop with asynchronous active-high reset to 0.
module d_ff (
  output logic q,
  input  logic d,
  input  logic reset,
  input  logic clk
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) q <= 1'b0;
    else       q <= d;
  end

endmodule

// File: rtl/param_dff.sv
// Parameterised pipeline of WIDTH x STAGES one-bit flops; q is d delayed by
// exactly STAGES rising edges, and every stage resets to RESET_VALUE.
module param_dff
  import param_dff_pkg::*;
#(
  parameter int               WIDTH       = 1,
  parameter int               STAGES      = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  input  logic             reset,
  input  logic             clk
);

  for (genvar w = 0; w < WIDTH; w++) begin : g_bit
    logic [STAGES-1:0] chain_q;

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
      if (s == 0) begin : g_first
        d_ff u_ff (
          .q     (chain_q[s]),
          .d     (stored_bit(d[w], RESET_VALUE[w])),
          .reset (reset),
          .clk   (clk)
        );
      end else begin : g_next
        d_ff u_ff (
          .q     (chain_q[s]),
          .d     (chain_q[s-1]),
          .reset (reset),
          .clk   (clk)
        );
      end
    end

    // Undo the storage inversion so a reset flop (0) presents RESET_VALUE.
    assign q[w] = stored_bit(chain_q[STAGES-1], RESET_VALUE[w]);
  end

endmodule

// File: tb/tb_param_dff.sv
// Directed bench for param_dff across four parameterisations sharing clk/reset.
module tb_param_dff;

  logic clk = 1'b0;
  logic reset;

  param_dff_if #(.WIDTH(1)) if1  ();
  param_dff_if #(.WIDTH(5)) if5  ();
  param_dff_if #(.WIDTH(5)) if53 ();
  param_dff_if #(.WIDTH(5)) if5r ();

  param_dff u_dut1 (.d(if1.d), .q(if1.q), .reset(reset), .clk(clk));

  param_dff #(.WIDTH(5), .STAGES(1)) u_dut5 (
    .d(if5.d), .q(if5.q), .reset(reset), .clk(clk));

  param_dff #(.WIDTH(5), .STAGES(3)) u_dut53 (
    .d(if53.d), .q(if53.q), .reset(reset), .clk(clk));

  param_dff #(.WIDTH(5), .STAGES(1), .RESET_VALUE(5'b10101)) u_dut5r (
    .d(if5r.d), .q(if5r.q), .reset(reset), .clk(clk));

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  logic [4:0] vec5 [3];
  logic [4:0] pipe_v [6];

  initial begin
    vec5   = '{5'd3, 5'd17, 5'd31};
    pipe_v = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6};

    reset   = 1'b1;
    if1.d   = 1'b1;
    if5.d   = 5'd0;
    if53.d  = 5'd9;
    if5r.d  = 5'd0;

    // Reset held across the first edge.
    @(negedge clk);
    check("rst_q1",   {7'd0, if1.q}, 8'd0);
    check("rst_q5",   {3'd0, if5.q}, 8'd0);
    check("rst_q53",  {3'd0, if53.q}, 8'd0);
    check("rst_q5r",  {3'd0, if5r.q}, 8'h15);

    reset = 1'b0;
    @(negedge clk);
    check("q1_first", {7'd0, if1.q}, 8'd1);
    check("q5r_first", {3'd0, if5r.q}, 8'd0);
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      check("q1_hold1", {7'd0, if1.q}, 8'd1);
    end

    if1.d = 1'b0;
    @(negedge clk);
    check("q1_fall", {7'd0, if1.q}, 8'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("q1_hold0", {7'd0, if1.q}, 8'd0);
    end

    // Width-5 single stage: each value one edge after it is driven, never sooner.
    for (int i = 0; i < 3; i++) begin
      if5.d = vec5[i];
      #1 check("q5_no_comb", {3'd0, if5.q}, (i == 0) ? 8'd0 : {3'd0, vec5[i-1]});
      @(negedge clk);
      check("q5_seq", {3'd0, if5.q}, {3'd0, vec5[i]});
    end

    // d=9 held long enough for the 3-stage pipe to be full.
    check("q53_full", {3'd0, if53.q}, 8'd9);

    // Mid-cycle reset pulse takes effect without a clock edge.
    #2 reset = 1'b1;
    #1;
    check("q53_async", {3'd0, if53.q}, 8'd0);
    check("q5_async",  {3'd0, if5.q},  8'd0);
    check("q5r_async", {3'd0, if5r.q}, 8'h15);
    #1 reset = 1'b0;
    @(negedge clk);
    check("q53_e1", {3'd0, if53.q}, 8'd0);
    @(negedge clk);
    check("q53_e2", {3'd0, if53.q}, 8'd0);
    @(negedge clk);
    check("q53_e3", {3'd0, if53.q}, 8'd9);

    // Reset held over several edges while every d toggles.
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if1.d  = i[0];
      if5.d  = 5'(i * 7 + 1);
      if53.d = 5'(31 - i);
      if5r.d = (i[0]) ? 5'b11111 : 5'b01010;
      @(negedge clk);
      check("hold_q1",  {7'd0, if1.q},  8'd0);
      check("hold_q5",  {3'd0, if5.q},  8'd0);
      check("hold_q53", {3'd0, if53.q}, 8'd0);
      check("hold_q5r", {3'd0, if5r.q}, 8'h15);
    end

    // Release and check bit independence through inverted storage and pipe order.
    reset  = 1'b0;
    if5r.d = 5'b01010;
    if53.d = pipe_v[0];
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      check("q53_pipe", {3'd0, if53.q}, (k >= 3) ? {3'd0, pipe_v[k-3]} : 8'd0);
      if (k == 1) begin
        check("q5r_01010", {3'd0, if5r.q}, 8'h0A);
        if5r.d = 5'b11111;
      end else if (k == 2) begin
        check("q5r_11111", {3'd0, if5r.q}, 8'h1F);
      end
      if (k < 6) if53.d = pipe_v[k];
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
